alu_serial: RTL and testbench

Digit-serial execute unit for the area-reduced core variant. Consumes the 3-bit ALU control code produced by the ALU decoder plus two register operands. Computes the result DIGIT bits per cycle, LSB digit first, and returns the result and flags through a valid/ready handshake. Sits between decode/operand fetch and the writeback/branch logic. A multicycle controller replaces the single-cycle combinational ALU.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_serial_if.sv | 29 ++
 rtl/alu_digit.sv | 36 +++
 rtl/alu_serial.sv | 111 +++++++++++
 tb/tb_alu_serial.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and controller state encoding for the serial
// execute unit and the ALU decoder.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // SUB and SLT both run as a + ~b + 1.
  function automatic logic uses_inv(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  function automatic logic is_logic(input logic [2:0] op);
    return (op == ALU_AND) || (op == ALU_OR);
  endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Request/response bundle of the serial ALU.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the sender holds its payload stable until that edge.
interface alu_serial_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, negative, carry, overflow
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, negative, carry, overflow
  );
endinterface

// File: rtl/alu_digit.sv
// Combinational DIGIT-bit ALU slice: add/sub with carry in/out, AND, OR.
// Also reports the carry into its MSB so the last slice can form overflow.
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             inv,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] y,
  output logic             cout,
  output logic             cmsb
);
  logic [DIGIT-1:0] bx;
  logic [DIGIT:0]   full;
  logic [DIGIT-1:0] low;

  assign bx   = b ^ {DIGIT{inv}};
  assign full = {1'b0, a} + {1'b0, bx} + {{DIGIT{1'b0}}, cin};
  // Sum of the lower DIGIT-1 bits; its top bit is the carry into the MSB.
  assign low  = {1'b0, a[DIGIT-2:0]} + {1'b0, bx[DIGIT-2:0]} + {{(DIGIT-1){1'b0}}, cin};
  assign cout = full[DIGIT];
  assign cmsb = low[DIGIT-1];

  always_comb begin
    y = full[DIGIT-1:0];
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = full[DIGIT-1:0];
    endcase
  end
endmodule

// File: rtl/alu_serial.sv
// Digit-serial execute unit: one DIGIT-wide slice per cycle, LSB digit first,
// result and flags returned through a valid/ready handshake.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  alu_serial_if.slave  bus,
  output state_t       dbg_state
);
  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_sh, b_sh, acc, result_r;
  logic [2:0]       op_r;
  logic             carry_r;
  logic             out_valid_r, zero_r, neg_r, carry_f, ovf_f;

  logic [DIGIT-1:0]       y;
  logic                   cout, cmsb, arith, last, ovf_w, carry_w;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       acc_next, final_res;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry_r),
    .inv  (uses_inv(op_r)),
    .op   (op_r),
    .y    (y),
    .cout (cout),
    .cmsb (cmsb)
  );

  assign arith     = ~is_logic(op_r);
  assign last      = (k == KW'(N - 1));
  assign cat       = {y, acc};
  assign acc_next  = cat[WIDTH+DIGIT-1:DIGIT];
  assign ovf_w     = arith & (cmsb ^ cout);
  assign carry_w   = arith & cout;
  // SLT: less-than is the sign of a-b corrected by overflow.
  assign final_res = (op_r == ALU_SLT) ? {{(WIDTH-1){1'b0}}, y[DIGIT-1] ^ ovf_w} : acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      acc         <= '0;
      op_r        <= ALU_ADD;
      carry_r     <= 1'b0;
      result_r    <= '0;
      out_valid_r <= 1'b0;
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      carry_f     <= 1'b0;
      ovf_f       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh    <= bus.src_a;
            b_sh    <= bus.src_b;
            op_r    <= bus.alu_control;
            carry_r <= uses_inv(bus.alu_control);
            k       <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          acc     <= acc_next;
          carry_r <= cout;
          k       <= k + 1'b1;
          if (last) begin
            result_r    <= final_res;
            zero_r      <= (final_res == '0);
            neg_r       <= final_res[WIDTH-1];
            carry_f     <= carry_w;
            ovf_f       <= ovf_w;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign bus.negative  = neg_r;
  assign bus.carry     = carry_f;
  assign bus.overflow  = ovf_f;
  assign dbg_state     = state;
endmodule

// File: tb/tb_alu_serial.sv
// Directed-vector bench for alu_serial with hand-computed results and flags.
module tb_alu_serial;
  import alu_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks;
  int     errors;
  logic [31:0] exp_q[$];

  alu_serial_if #(.WIDTH(32)) bus ();

  alu_serial #(.WIDTH(32), .DIGIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {zero, negative, carry, overflow}
  function automatic logic [31:0] flags();
    return {28'b0, bus.zero, bus.negative, bus.carry, bus.overflow};
  endfunction

  // driver tasks
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    check("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp_flags);
    int lat;
    logic [31:0] exp_res;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check({tag, "_latency"}, lat, 32'd4);
    exp_res = exp_q.pop_front();
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_flags"}, flags(), exp_flags);
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_out_valid_drop"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic [31:0] exp_flags);
    exp_q.push_back(exp_res);
    start_op(op, a, b);
    wait_done(tag, exp_flags);
    consume(tag);
  endtask

  initial begin
    logic [31:0] held_res;
    logic [31:0] held_flags;
    checks = 0;
    errors = 0;
    bus.in_valid    = 1'b0;
    bus.alu_control = ALU_ADD;
    bus.src_a       = '0;
    bus.src_b       = '0;
    bus.out_ready   = 1'b0;
    rst             = 1'b1;

    #3;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", flags(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);

    run_op("add",      ALU_ADD, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 32'b0000);
    run_op("sub_eq",   ALU_SUB, 32'd5,         32'd5,         32'd0,         32'b1010);
    run_op("sub_ovf",  ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'b0011);
    run_op("slt_m1_1", ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1,         32'b0010);
    run_op("slt_1_m1", ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0,         32'b1000);
    run_op("slt_pmax", ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         32'b1001);
    run_op("slt_nmin", ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         32'b0011);
    run_op("and",      ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'b0100);
    run_op("or",       ALU_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 32'b0100);
    run_op("code111",  3'b111,  32'd2,         32'd3,         32'd5,         32'b0000);

    // backpressure: hold result in DONE while new requests are offered
    exp_q.push_back(32'h0000_000D);
    start_op(ALU_SUB, 32'h10, 32'h3);
    wait_done("bp", 32'b0010);
    held_res   = bus.result;
    held_flags = flags();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid    = 1'b1;
      bus.alu_control = 3'($urandom_range(0, 7));
      bus.src_a       = $urandom;
      bus.src_b       = $urandom;
      @(negedge clk);
      check("bp_result_hold", bus.result, held_res);
      check("bp_flags_hold", flags(), held_flags);
      check("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
      check("bp_out_valid_hold", {31'b0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_consumed", {31'b0, bus.out_valid}, 32'd0);
    check("bp_no_accept", {30'b0, dbg_state}, {30'b0, IDLE});
    bus.in_valid = 1'b0;
    run_op("bp_second", ALU_ADD, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 32'b0000);

    // asynchronous reset at k = 2
    start_op(ALU_ADD, 32'h11, 32'h22);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_flags", flags(), 32'd0);
    check("arst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("arst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    @(negedge clk);
    check("arst_in_ready_hold", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    #1 check("arst_release_ready", {31'b0, bus.in_ready}, 32'd1);
    run_op("post_rst", ALU_ADD, 32'd7, 32'd8, 32'd15, 32'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
